sdspi_host_arbiter: RTL and testbench
=====================================

// Module: sdspi_host_arbiter
// PURPOSE
//  Shares one SD SPI host among N_REQ requesters, e.g. the autotest sequencer and the UUT.
//  Replaces the static uut_ctrl_mux select with round-robin, session-locked arbitration.
//  Includes a watchdog that reclaims a stuck session.
//  Sits between the requesters' SPI command bundles and the single SD SPI host instance.
// PARAMETERS
//  N_REQ           2          number of requesters (2..8)
//  TIMEOUT_CYCLES  32'h6E00000  max cycles one session may hold the grant
// PORTS
//  clk               in   1          system clock
//  rst_n             in   1          asynchronous, active-low reset
//  req_rst           in   N_REQ      per-requester spi_rst
//  req_r_block       in   N_REQ      per-requester r_block
//  req_r_multi_block in   N_REQ      per-requester r_multi_block
//  req_w_block       in   N_REQ      per-requester w_block
//  req_r_byte        in   N_REQ      per-requester r_byte strobe
//  req_w_byte        in   N_REQ      per-requester w_byte strobe
//  req_block_addr    in   32*N_REQ   per-requester block address, packed, req i at [32i+31:32i]
//  req_data_in       in   8*N_REQ    per-requester write byte, packed
//  req_busy          out  N_REQ      busy returned to each requester
//  req_err           out  N_REQ      spi_err, routed to the granted requester only
//  req_crc_err       out  N_REQ      spi_crc_err, routed to the granted requester only
//  req_data_out      out  8          spi_data_out, broadcast; valid for the granted requester
//  spi_rst, spi_r_block, spi_r_multi_block, spi_w_block, spi_r_byte, spi_w_byte
//                    out  1 each     strobes to the host
//  spi_block_addr    out  32         to host
//  spi_data_in       out  8          to host
//  spi_busy, spi_err, spi_crc_err  in  1 each  from host
//  grant             out  N_REQ      one-hot current grant
//  timeout_err       out  1          one-cycle pulse when the watchdog fires
// BEHAVIOUR
//  - Reset values: state=IDLE, grant=0, last=N_REQ-1, wdog=0, timeout_err=0.
//    With no grant, all spi_* strobes=0, spi_block_addr=0, spi_data_in=8'hFF.
//  - session[i] = req_rst|req_r_block|req_r_multi_block|req_w_block for requester i.
//    Byte strobes alone never open a session.
//  - IDLE: if any session bit is set, pick the first set bit after `last`, cyclically.
//    Register the one-hot grant and go to GRANT. Latency is 1 cycle from request to grant.
//  - GRANT: host outputs are a combinational mux of the granted bundle. wdog increments every cycle.
//    - Granted session drops and spi_busy=0 -> IDLE; last <= granted index.
//    - Granted session drops and spi_busy=1 -> DRAIN.
//    - wdog == TIMEOUT_CYCLES-1 -> DRAIN, pulse timeout_err.
//      Priority: the timeout wins over a simultaneous session drop.
//  - DRAIN: grant is still held, but all host strobes are forced to 0. Wait for spi_busy=0,
//    then -> IDLE, last <= granted index, wdog <= 0.
//  - req_busy[i]: granted and in GRANT -> spi_busy.
//    Not granted, or in DRAIN, with session[i]=1 -> 1, so the requester stalls.
//    Otherwise -> 0, so an idle requester can never deadlock waiting for busy low.
//  - A session that re-asserts in the same cycle as its release is not re-granted
//    while another requester is pending (round-robin fairness).
//  - rst_n asserted mid-session: everything returns to reset values immediately.
//    No spi_rst is generated; the requester restarts its own host reset sequence.
//  - wdog is 32 bits, saturates, and clears on every entry to IDLE.
// STRUCTURE
//  - Package sdspi_arb_pkg: typedef enum logic[1:0] {IDLE,GRANT,DRAIN} arb_state_t;
//    localparam SPI_IDLE_BYTE = 8'hFF.
//  - Sub-module rr_picker #(N): comb; inputs req and last, outputs one-hot pick and its index.
//  - The top holds the FSM, the grant/last registers, the watchdog counter and the output muxes.
// TESTING
//  1. Reset, then req0 asserts r_block -> grant=2'b01 one cycle later;
//     spi_block_addr follows req0 addr 0x00100000.
//  2. req0 and req1 assert together from IDLE with last=1 -> req0 granted.
//     Release req0 -> req1 granted next; req0 sees req_busy=1 while waiting.
//  3. req0 drops r_block while spi_busy=1 -> DRAIN with strobes 0; on busy=0 -> IDLE,
//     then the next grant goes to req1 if it is pending.
//  4. TIMEOUT_CYCLES=16; req0 holds w_block forever -> after 16 cycles timeout_err pulses once,
//     DRAIN, and the grant passes to req1.
//  5. rst_n low in mid-GRANT, 3 cycles into a session -> grant=0 asynchronously,
//     spi_data_in=8'hFF, timeout_err=0.
//  6. Idle req1 (no session) while req0 is granted -> req_busy[1]=0; req_err[1]=0
//     even when spi_err=1.

Source files
------------

// File: rtl/sdspi_arb_pkg.sv
// Shared types for the SD SPI host arbiter.
// Arbiter FSM states and the idle value driven on the host data bus.
package sdspi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DRAIN
  } arb_state_t;

  localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/sdspi_host_arbiter_rr_picker.sv
// Round-robin picker: first set request after `last`, cyclically.
// Combinational; returns a one-hot pick and its index.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);

  int   j;
  logic found;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = int'(last) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found   = 1'b1;
        pick[j] = 1'b1;
        idx     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sdspi_host_arbiter.sv
// Round-robin, session-locked arbiter sharing one SD SPI host.
// A watchdog reclaims sessions that hold the grant too long.
module sdspi_host_arbiter
  import sdspi_arb_pkg::*;
#(
  parameter int          N_REQ          = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'h6E00000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_rst,
  input  logic [N_REQ-1:0]      req_r_block,
  input  logic [N_REQ-1:0]      req_r_multi_block,
  input  logic [N_REQ-1:0]      req_w_block,
  input  logic [N_REQ-1:0]      req_r_byte,
  input  logic [N_REQ-1:0]      req_w_byte,
  input  logic [32*N_REQ-1:0]   req_block_addr,
  input  logic [8*N_REQ-1:0]    req_data_in,
  output logic [N_REQ-1:0]      req_busy,
  output logic [N_REQ-1:0]      req_err,
  output logic [N_REQ-1:0]      req_crc_err,
  output logic [7:0]            req_data_out,
  output logic                  spi_rst,
  output logic                  spi_r_block,
  output logic                  spi_r_multi_block,
  output logic                  spi_w_block,
  output logic                  spi_r_byte,
  output logic                  spi_w_byte,
  output logic [31:0]           spi_block_addr,
  output logic [7:0]            spi_data_in,
  input  logic                  spi_busy,
  input  logic                  spi_err,
  input  logic                  spi_crc_err,
  input  logic [7:0]            spi_data_out,
  output logic [N_REQ-1:0]      grant,
  output logic                  timeout_err
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    last_q, last_d;
  logic [31:0]      wdog_q, wdog_d;
  logic             tmo_q, tmo_d;

  logic [N_REQ-1:0] session;
  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             gsess;

  assign session = req_rst | req_r_block | req_r_multi_block | req_w_block;
  assign gsess   = |(session & grant_q);

  rr_picker #(.N(N_REQ), .IW(IW)) u_pick (
    .req  (session),
    .last (last_q),
    .pick (pick),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (|session) begin
          grant_d = pick;
          idx_d   = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (wdog_q != '1) wdog_d = wdog_q + 32'd1;
        // Timeout takes precedence over a coincident session drop
        if (wdog_q == TIMEOUT_CYCLES - 32'd1) begin
          state_d = DRAIN;
          tmo_d   = 1'b1;
        end else if (!gsess) begin
          if (spi_busy) begin
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = idx_q;
            wdog_d  = '0;
          end
        end
      end
      DRAIN: begin
        if (!spi_busy) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = idx_q;
          wdog_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      wdog_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    spi_rst           = 1'b0;
    spi_r_block       = 1'b0;
    spi_r_multi_block = 1'b0;
    spi_w_block       = 1'b0;
    spi_r_byte        = 1'b0;
    spi_w_byte        = 1'b0;
    spi_block_addr    = '0;
    spi_data_in       = SPI_IDLE_BYTE;
    if (state_q == GRANT) begin
      spi_rst           = req_rst[idx_q];
      spi_r_block       = req_r_block[idx_q];
      spi_r_multi_block = req_r_multi_block[idx_q];
      spi_w_block       = req_w_block[idx_q];
      spi_r_byte        = req_r_byte[idx_q];
      spi_w_byte        = req_w_byte[idx_q];
    end
    if (|grant_q) begin
      spi_block_addr = req_block_addr[32*int'(idx_q) +: 32];
      spi_data_in    = req_data_in[8*int'(idx_q) +: 8];
    end
  end

  // Requesters without a session never see busy, so they cannot deadlock
  always_comb begin
    req_busy = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i] && state_q == GRANT) req_busy[i] = spi_busy;
      else                                req_busy[i] = session[i];
    end
  end

  assign req_err      = grant_q & {N_REQ{spi_err}};
  assign req_crc_err  = grant_q & {N_REQ{spi_crc_err}};
  assign req_data_out = spi_data_out;
  assign grant        = grant_q;
  assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_sdspi_host_arbiter.sv
// Bench for sdspi_host_arbiter: directed scenarios then random traffic,
// checked every cycle against an owner/last/hold-count model.
module tb_sdspi_host_arbiter;

  localparam int NR = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] rs = '0, rb = '0, rmb = '0, wb = '0, rby = '0, wby = '0;
  logic [32*NR-1:0] addr = '0;
  logic [8*NR-1:0]  din = '0;
  logic          busy = 1'b0, err = 1'b0, crc = 1'b0;
  logic [7:0]    sdo = '0;

  logic [NR-1:0] req_busy, req_err, req_crc_err, grant;
  logic [7:0]    req_data_out, spi_data_in;
  logic          s_rst, s_rb, s_rmb, s_wb, s_rby, s_wby, tmo;
  logic [31:0]   spi_block_addr;

  int checks = 0;
  int errors = 0;

  int m_owner, m_last, m_held;
  bit m_drain, m_tmo;

  sdspi_host_arbiter #(.N_REQ(NR), .TIMEOUT_CYCLES(32'd16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_rst(rs), .req_r_block(rb), .req_r_multi_block(rmb),
    .req_w_block(wb), .req_r_byte(rby), .req_w_byte(wby),
    .req_block_addr(addr), .req_data_in(din),
    .req_busy(req_busy), .req_err(req_err), .req_crc_err(req_crc_err),
    .req_data_out(req_data_out),
    .spi_rst(s_rst), .spi_r_block(s_rb), .spi_r_multi_block(s_rmb),
    .spi_w_block(s_wb), .spi_r_byte(s_rby), .spi_w_byte(s_wby),
    .spi_block_addr(spi_block_addr), .spi_data_in(spi_data_in),
    .spi_busy(busy), .spi_err(err), .spi_crc_err(crc),
    .spi_data_out(sdo), .grant(grant), .timeout_err(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit sess(int i);
    return rs[i] | rb[i] | rmb[i] | wb[i];
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = NR - 1;
    m_held  = 0;
    m_drain = 0;
    m_tmo   = 0;
  endtask

  task automatic model_update();
    bit nt = 0;
    if (m_owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        int j = (m_last + k) % NR;
        if (m_owner < 0 && sess(j)) m_owner = j;
      end
      m_held  = 0;
      m_drain = 0;
    end else if (!m_drain) begin
      if (m_held == TO - 1) begin
        m_drain = 1;
        nt = 1;
      end else if (!sess(m_owner)) begin
        if (busy) m_drain = 1;
        else begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
      m_held++;
    end else if (!busy) begin
      m_last  = m_owner;
      m_owner = -1;
      m_drain = 0;
    end
    m_tmo = nt;
  endtask

  task automatic check_all();
    logic [NR-1:0] eg, eb, ee, ec;
    logic [5:0]    es;
    logic [31:0]   ea;
    logic [7:0]    ed;
    bit            live;
    eg = '0; eb = '0; ee = '0; ec = '0;
    es = '0; ea = '0; ed = 8'hFF;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ee[m_owner] = err;
      ec[m_owner] = crc;
      ea = addr[32*m_owner +: 32];
      ed = din[8*m_owner +: 8];
      if (!m_drain)
        es = {rs[m_owner], rb[m_owner], rmb[m_owner],
              wb[m_owner], rby[m_owner], wby[m_owner]};
    end
    for (int i = 0; i < NR; i++) begin
      live = (i == m_owner) && !m_drain;
      eb[i] = live ? busy : sess(i);
    end
    chk("grant", 64'(grant), 64'(eg));
    chk("strobes", 64'({s_rst, s_rb, s_rmb, s_wb, s_rby, s_wby}), 64'(es));
    chk("addr", 64'(spi_block_addr), 64'(ea));
    chk("data_in", 64'(spi_data_in), 64'(ed));
    chk("req_busy", 64'(req_busy), 64'(eb));
    chk("req_err", 64'(req_err), 64'(ee));
    chk("req_crc", 64'(req_crc_err), 64'(ec));
    chk("data_out", 64'(req_data_out), 64'(sdo));
    chk("timeout", 64'(tmo), 64'(m_tmo));
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    int pulses;
    model_reset();
    #3;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_data", 64'(spi_data_in), 64'hFF);
    chk("rst_addr", 64'(spi_block_addr), 64'h0);
    chk("rst_tmo", 64'(tmo), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic grant of req0
    addr[31:0] = 32'h0010_0000;
    addr[63:32] = 32'h0000_0200;
    din = 16'hA55A;
    rb = 2'b01;
    step();
    chk("t1_grant", 64'(grant), 64'h1);
    chk("t1_addr", 64'(spi_block_addr), 64'h0010_0000);
    step();
    rb = 2'b00;
    step(); step();

    // Give req1 a turn so last=1, then both contend
    rb = 2'b10;
    step(); step();
    rb = 2'b00;
    step(); step();
    rb = 2'b11;
    step();
    chk("t2_grant0", 64'(grant), 64'h1);
    step();
    chk("t2_wait_busy", 64'(req_busy[1]), 64'h1);
    rb = 2'b10;
    step(); step();
    chk("t2_grant1", 64'(grant), 64'h2);
    rb = 2'b00;
    step(); step();

    // Drop while host busy -> drain, then req1
    rb = 2'b01;
    step(); step();
    busy = 1'b1;
    rb = 2'b10;
    step();
    chk("t3_drain_strb", 64'(s_rb), 64'h0);
    step();
    busy = 1'b0;
    step(); step();
    chk("t3_grant1", 64'(grant), 64'h2);
    rb = 2'b00;
    step(); step();

    // Watchdog: req0 holds forever
    wb = 2'b01;
    rb = 2'b10;
    pulses = 0;
    for (int c = 0; c < 22; c++) begin
      step();
      if (tmo) pulses++;
    end
    chk("t4_pulses", 64'(pulses), 64'h1);
    chk("t4_grant1", 64'(grant), 64'h2);
    wb = 2'b00;
    rb = 2'b00;
    step(); step(); step();

    // Asynchronous reset mid-session
    rb = 2'b01;
    step(); step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_grant", 64'(grant), 64'h0);
    chk("t5_data", 64'(spi_data_in), 64'hFF);
    chk("t5_tmo", 64'(tmo), 64'h0);
    chk("t5_strb", 64'(s_rb), 64'h0);
    rb = 2'b00;
    model_reset();
    rst_n = 1'b1;
    step();

    // Idle requester sees neither busy nor err
    rb = 2'b01;
    step(); step();
    err = 1'b1;
    busy = 1'b1;
    #1;
    chk("t6_busy1", 64'(req_busy[1]), 64'h0);
    chk("t6_err1", 64'(req_err[1]), 64'h0);
    chk("t6_err0", 64'(req_err[0]), 64'h1);
    step();
    err = 1'b0;
    busy = 1'b0;
    rb = 2'b00;
    step(); step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(7) == 0) rb[i] = ~rb[i];
        if ($urandom_range(31) == 0) wb[i] = ~wb[i];
        if ($urandom_range(31) == 0) rmb[i] = ~rmb[i];
        rs[i] = ($urandom_range(63) == 0);
      end
      rby  = 2'($urandom);
      wby  = 2'($urandom);
      busy = ($urandom_range(2) == 0);
      err  = ($urandom_range(5) == 0);
      crc  = ($urandom_range(5) == 0);
      sdo  = 8'($urandom);
      din  = 16'($urandom);
      if ($urandom_range(3) == 0) addr = {$urandom, $urandom};
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
